pwm_demodulator: RTL
====================

PWM_DEMODULATOR -- requirements
Module: pwm_demodulator

Interface
REQ-001 SHALL have parameter AM_CLKS_IN_PWM_STEPS, default `AM_CLKS_IN_PWM_STEPS, clk cycles per PWM step; legal range >=2.
REQ-002 SHALL have parameter AM_PWM_STEPS, default `AM_PWM_STEPS, PWM steps per symbol; legal range >=2.
REQ-003 SHALL have localparam W = $clog2(AM_PWM_STEPS+1), the sample width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pwm_in, input, 1, asynchronous serial PWM stream in the modulator's format: each symbol is left-aligned high, one run of N high steps then low steps, with N in 0..AM_PWM_STEPS.
REQ-007 SHALL have port sample, output, W, the last recovered duty value N.
REQ-008 SHALL have port sample_valid, output, 1, a one-cycle pulse when sample updates.
REQ-009 SHALL have port locked, output, 1, high while symbol framing is established.
REQ-010 SHALL have port sync_err, output, 1, a one-cycle pulse when framing is lost.

Function
REQ-011 SHALL pass pwm_in through a 2-flop synchronizer; all further logic uses the synchronized signal s.
REQ-012 SHALL detect a rising edge as s==1 while the previous s==0 (3rd flop), within the same cycle s becomes 1.
REQ-013 SHALL implement an FSM with states HUNT and LOCKED; locked==1 iff state==LOCKED.
REQ-014 SHALL keep a phase counter 0..AM_CLKS_IN_PWM_STEPS-1, a step counter 0..AM_PWM_STEPS-1 and a ones accumulator of width W.
REQ-015 SHALL, in HUNT, on a rising edge: go to LOCKED, treat that cycle as step 0 phase 0 (next cycle phase=1, step=0) and set ones to 0.
REQ-016 SHALL, in LOCKED, increment phase every cycle; at phase wrap, step increments; at step wrap (AM_PWM_STEPS-1 to 0), the symbol ends.
REQ-017 SHALL, in LOCKED, sample s at phase == AM_CLKS_IN_PWM_STEPS/2 (integer division) and add 1 to ones if s==1.
REQ-018 SHALL, on the end-of-symbol cycle (step AM_PWM_STEPS-1, phase max), load sample <= ones (including that step's sample), pulse sample_valid on the following cycle together with the new sample, and clear ones.
REQ-019 SHALL consider a rising edge expected only at step 0 phase 0 in LOCKED; the edge is absent for N=0 and N=AM_PWM_STEPS, and absence SHALL NOT be an error.
REQ-020 SHALL, on a rising edge in LOCKED at any other position: go to HUNT, pulse sync_err for one cycle, discard ones, not pulse sample_valid, and not use that edge for realignment (the next rising edge relocks).
REQ-021 SHALL hold sample between valid pulses; sample_valid SHALL never be asserted in HUNT or in the first cycle after relock.
REQ-022 SHALL saturate: ones cannot exceed AM_PWM_STEPS by construction; no wrap of the W-bit accumulator.

Reset
REQ-023 SHALL, while rst==0 (asynchronously), clear the synchronizer flops, state=HUNT, phase=0, step=0, ones=0, sample=0, sample_valid=0, locked=0, sync_err=0.
REQ-024 SHALL, on reset asserted mid-symbol, discard the partial symbol; after release, the FSM waits in HUNT for a new rising edge.

Verification (AM_CLKS_IN_PWM_STEPS=4, AM_PWM_STEPS=8, W=4)
REQ-025 SHALL test: after reset, drive repeated symbols of 12 high + 20 low cycles -> locked rises 3 cycles after the first pwm_in rise; sample=3 with sample_valid pulses every 32 cycles; sync_err stays 0.
REQ-026 SHALL test: a locked stream, then symbols of N=0 (all low) and N=8 (all high) -> sample=0 and sample=8 respectively; locked stays 1; no sync_err.
REQ-027 SHALL test: a locked stream with N=5, then one symbol shifted by 6 cycles -> sync_err pulses once at the misplaced edge, locked=0, no sample_valid for that symbol; the following edge relocks and sample=5 is resumed.
REQ-028 SHALL test: stream N=2, then N=7, then N=1 -> sample sequence 2,7,1, each with exactly one valid pulse.
REQ-029 SHALL test: rst asserted low mid-symbol, asynchronous to clk -> all outputs 0 immediately; after release, no sample_valid until one full symbol after the next rising edge.

Source files
------------

// File: rtl/pwm_demodulator.sv
// Recovers the duty value of a left-aligned PWM symbol stream, framing on the
// leading rising edge of each symbol and reporting loss of framing.
`ifndef AM_CLKS_IN_PWM_STEPS
`define AM_CLKS_IN_PWM_STEPS 4
`endif
`ifndef AM_PWM_STEPS
`define AM_PWM_STEPS 8
`endif

module pwm_demodulator #(
  parameter int AM_CLKS_IN_PWM_STEPS = `AM_CLKS_IN_PWM_STEPS,
  parameter int AM_PWM_STEPS         = `AM_PWM_STEPS,
  localparam int W                   = $clog2(AM_PWM_STEPS+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [W-1:0] sample,
  output logic         sample_valid,
  output logic         locked,
  output logic         sync_err
);

  localparam int PW = $clog2(AM_CLKS_IN_PWM_STEPS);
  localparam int SW = $clog2(AM_PWM_STEPS);
  localparam logic [PW-1:0] PH_MAX   = PW'(AM_CLKS_IN_PWM_STEPS-1);
  localparam logic [PW-1:0] PH_MID   = PW'(AM_CLKS_IN_PWM_STEPS/2);
  localparam logic [SW-1:0] ST_MAX   = SW'(AM_PWM_STEPS-1);
  localparam logic [W-1:0]  ONES_MAX = W'(AM_PWM_STEPS);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [SW-1:0] step, step_n;
  logic [W-1:0]  ones, ones_n, ones_acc, sample_n;
  logic          valid_n, err_n;
  logic          s_meta, s, s_prev, rise, hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= pwm_in;
      s      <= s_meta;
      s_prev <= s;
    end
  end

  assign rise   = s & ~s_prev;
  assign hit    = (phase == PH_MID) & s;
  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= HUNT;
      phase        <= '0;
      step         <= '0;
      ones         <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      step         <= step_n;
      ones         <= ones_n;
      sample       <= sample_n;
      sample_valid <= valid_n;
      sync_err     <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    step_n   = step;
    ones_n   = ones;
    sample_n = sample;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    ones_acc = (hit && ones != ONES_MAX) ? ones + W'(1) : ones;
    case (state)
      HUNT: begin
        step_n = '0;
        ones_n = '0;
        // The edge cycle is step 0 phase 0, so counting resumes at phase 1.
        phase_n = rise ? PW'(1) : '0;
        if (rise) state_n = LOCKED;
      end
      LOCKED: begin
        if (rise && (phase != '0 || step != '0)) begin
          // Misplaced edge: drop the partial symbol; the next edge relocks.
          state_n = HUNT;
          err_n   = 1'b1;
          phase_n = '0;
          step_n  = '0;
          ones_n  = '0;
        end else if (phase == PH_MAX) begin
          phase_n = '0;
          if (step == ST_MAX) begin
            step_n   = '0;
            sample_n = ones_acc;
            valid_n  = 1'b1;
            ones_n   = '0;
          end else begin
            step_n = step + SW'(1);
            ones_n = ones_acc;
          end
        end else begin
          phase_n = phase + PW'(1);
          ones_n  = ones_acc;
        end
      end
      default: state_n = HUNT;
    endcase
  end

endmodule
